seq_product_accumulator: RTL and testbench

//  Downstream consumer of the 32x32 signed sequential multiplier. Accepts a

---
 rtl/seq_product_accumulator.sv | 123 ++++++++++++
 tb/tb_seq_product_accumulator.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_product_accumulator.sv
// seq_product_accumulator
//   Sums a programmed number of signed PROD_W-bit products, delivered over a
//   valid/ready handshake, into a signed ACC_W-bit accumulator. The final sum
//   is returned over a valid/ready result port. This block is the MAC tail
//   that follows the 32x32 signed sequential multiplier.
//
//   Build option: define ACC_SATURATE_EN to clamp the accumulator on signed
//   overflow. When it is undefined, the accumulator wraps modulo 2**ACC_W.
//   The sticky overflow flag is raised in both builds.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   start       begin a job (only sampled in IDLE)
//   len         number of products in the job, sampled with start (0 = empty job)
//   prod_valid  prod carries a valid product
//   prod        signed product
//   prod_ready  block accepts prod this cycle (ACCUM only)
//   acc_valid   acc holds the final sum (DONE)
//   acc_ready   consumer takes acc
//   acc         signed accumulated result; held in IDLE until the next start
//   busy        state is not IDLE
//   overflow    sticky signed overflow for the current job
module seq_product_accumulator #(
    parameter int PROD_W = 64,
    parameter int ACC_W  = 72,   // must exceed PROD_W
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    output logic              prod_ready,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              busy,
    output logic              overflow
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t            state, state_nxt;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  count;
    logic [ACC_W-1:0]  addend;
    logic [ACC_W-1:0]  sum;
    logic              add_ovf;
    logic              xfer;
    logic              last;

    assign addend  = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    assign sum     = acc + addend;
    // Overflow: the addends share a sign and the sum's sign differs from it.
    assign add_ovf = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign xfer    = prod_valid && prod_ready;
    assign last    = (count == (len_q - 1'b1));

    always_comb begin
        state_nxt  = state;
        prod_ready = 1'b0;
        acc_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = (len != '0) ? ACCUM : DONE;
            end
            ACCUM: begin
                prod_ready = 1'b1;
                if (xfer && last) state_nxt = DONE;
            end
            DONE: begin
                acc_valid = 1'b1;
                // start is not looked at here; a new job can begin only once back in IDLE
                if (acc_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            overflow <= 1'b0;
            count    <= '0;
            len_q    <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        count    <= '0;
                        len_q    <= len;
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        count <= count + 1'b1;
                        if (add_ovf) begin
                            overflow <= 1'b1;
`ifdef ACC_SATURATE_EN
                            // Clamp toward the common sign of the addends.
                            acc <= addend[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                                   : {1'b0, {(ACC_W-1){1'b1}}};
`else
                            acc <= sum;
`endif
                        end else begin
                            acc <= sum;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_product_accumulator.sv
module tb_seq_product_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        prod_valid;
    logic [63:0] prod;
    logic        acc_ready;

    logic        prod_ready72, acc_valid72, busy72, overflow72;
    logic [71:0] acc72;
    logic        prod_ready66, acc_valid66, busy66, overflow66;
    logic [65:0] acc66;

    always #5 clk = ~clk;

    // Both instances see the same stimulus; sel66 picks which one is checked.
    seq_product_accumulator dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready72),
        .acc_valid(acc_valid72), .acc_ready(acc_ready), .acc(acc72),
        .busy(busy72), .overflow(overflow72));

    seq_product_accumulator #(.ACC_W(66)) dut66 (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .prod_valid(prod_valid), .prod(prod), .prod_ready(prod_ready66),
        .acc_valid(acc_valid66), .acc_ready(acc_ready), .acc(acc66),
        .busy(busy66), .overflow(overflow66));

    bit           sel66 = 1'b0;
    logic         prod_ready, acc_valid, busy, overflow;
    logic [127:0] acc;

    always_comb begin
        prod_ready = sel66 ? prod_ready66 : prod_ready72;
        acc_valid  = sel66 ? acc_valid66  : acc_valid72;
        busy       = sel66 ? busy66       : busy72;
        overflow   = sel66 ? overflow66   : overflow72;
        acc        = sel66 ? {62'd0, acc66} : {56'd0, acc72};
    end

    typedef struct {
        logic [127:0] acc;
        logic         ovf;
    } exp_t;

    exp_t                  sb[$];
    logic signed [63:0]    pv[$];
    logic signed [127:0]   m_acc;
    logic                  m_ovf;
    int                    n_tests = 0;
    int                    n_fail  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int width();
        return sel66 ? 66 : 72;
    endfunction

    // Reference: ideal wide sum, then range-check against the selected width.
    task automatic m_add(input logic signed [63:0] p);
        logic signed [127:0] mx, mn, span;
        span  = 128'sd1 <<< width();
        mx    = (128'sd1 <<< (width() - 1)) - 128'sd1;
        mn    = -(128'sd1 <<< (width() - 1));
        m_acc = m_acc + p;
        if (m_acc > mx || m_acc < mn) begin
            m_ovf = 1'b1;
`ifdef ACC_SATURATE_EN
            m_acc = (m_acc > mx) ? mx : mn;
`else
            m_acc = (m_acc > mx) ? m_acc - span : m_acc + span;
`endif
        end
    endtask

    function automatic logic [127:0] m_bits();
        logic [127:0] mask;
        mask = (128'd1 << width()) - 128'd1;
        return m_acc & mask;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_job(input int n);
        m_acc = '0;
        m_ovf = 1'b0;
        start = 1'b1;
        len   = 8'(n);
        tick();
        start = 1'b0;
        if (n != 0) begin
            chk("start_busy", {126'd0, busy, prod_ready}, 128'd3);
        end else begin
            chk("len0_done", {126'd0, acc_valid, prod_ready}, 128'd2);
            sb.push_back('{acc: 128'd0, ovf: 1'b0});
        end
    endtask

    // Feed up to nmax products from pv with 'gap' idle cycles before each.
    task automatic feed(input int gap, input int nmax);
        int i;
        for (i = 0; i < pv.size() && i < nmax; i++) begin
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_hold", {127'd0, acc_valid}, 128'd0);
            end
            chk("prod_ready", {127'd0, prod_ready}, 128'd1);
            prod_valid = 1'b1;
            prod       = pv[i];
            m_add(pv[i]);
            tick();
            prod_valid = 1'b0;
        end
        if (i == pv.size()) begin
            sb.push_back('{acc: m_bits(), ovf: m_ovf});
            chk("latency", {127'd0, acc_valid}, 128'd1);
        end
    endtask

    task automatic take_result(input string tag, input int hold, input bit poke);
        int   t = 0;
        exp_t e;
        while (acc_valid !== 1'b1 && t < 50) begin
            tick();
            t++;
        end
        if (acc_valid !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout waiting for acc_valid", tag);
            return;
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s result with empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                start = 1'b1;
                len   = 8'd3;
            end
            tick();
            chk({tag, "_hold_acc"}, acc, e.acc);
            chk({tag, "_hold_hs"}, {126'd0, acc_valid, prod_ready}, 128'd2);
        end
        chk({tag, "_acc"}, acc, e.acc);
        chk({tag, "_ovf"}, {127'd0, overflow}, {127'd0, e.ovf});
        acc_ready = 1'b1;
        if (poke) begin
            start = 1'b1;
            len   = 8'd3;
        end
        tick();
        acc_ready = 1'b0;
        start     = 1'b0;
        chk({tag, "_idle"}, {126'd0, acc_valid, busy}, 128'd0);
        tick();
        chk({tag, "_idle2"}, {125'd0, acc_valid, busy, prod_ready}, 128'd0);
        chk({tag, "_kept"}, acc, e.acc);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        len        = '0;
        prod_valid = 1'b0;
        prod       = '0;
        acc_ready  = 1'b0;
        tick();
        tick();
        chk("reset_acc", acc, 128'd0);
        chk("reset_flags", {124'd0, acc_valid, prod_ready, busy, overflow}, 128'd0);
        reset = 1'b0;
        tick();

        // 1: mixed signs, back-to-back
        pv = '{64'sd6, -64'sd10, 64'sd100};
        start_job(3);
        feed(0, 99);
        take_result("t1", 0, 0);

        // 2: two max-positive products with idle gaps
        pv = '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF};
        start_job(2);
        feed(3, 99);
        take_result("t2", 0, 0);

        // 3: empty job
        start_job(0);
        take_result("t3", 0, 0);

        // 5: reset after two of five transfers abandons the job
        pv = '{64'sd1, 64'sd2, 64'sd3, 64'sd4, 64'sd5};
        start_job(5);
        feed(0, 2);
        reset = 1'b1;
        tick();
        chk("midreset_acc", acc, 128'd0);
        chk("midreset_flags", {124'd0, acc_valid, prod_ready, busy, overflow}, 128'd0);
        reset = 1'b0;
        tick();
        chk("midreset_idle", {127'd0, busy}, 128'd0);
        pv = '{-64'sd7};
        start_job(1);
        feed(0, 99);
        take_result("t5", 0, 0);

        // 6: stall in DONE with start pulsed, then handshake with start still high
        pv = '{64'sd11, 64'sd22, 64'sd33};
        start_job(3);
        feed(1, 99);
        take_result("t6", 5, 1);

        // 4: narrow accumulator, overflow behaviour
        sel66 = 1'b1;
        pv = '{64'sh4000_0000_0000_0000, 64'sh4000_0000_0000_0000,
               64'sh4000_0000_0000_0000, 64'sh4000_0000_0000_0000};
        start_job(4);
        feed(0, 99);
        take_result("t4a", 0, 0);

        pv = '{64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF,
               64'sh7FFF_FFFF_FFFF_FFFF, 64'sh7FFF_FFFF_FFFF_FFFF, -64'sd1};
        start_job(6);
        feed(0, 99);
        take_result("t4b", 0, 0);

        pv = '{64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000,
               64'sh8000_0000_0000_0000, 64'sh8000_0000_0000_0000};
        start_job(5);
        feed(0, 99);
        take_result("t4c", 0, 0);

        // overflow flag clears on the next accepted start
        pv = '{64'sd1};
        start_job(1);
        chk("ovf_cleared", {127'd0, overflow}, 128'd0);
        feed(0, 99);
        take_result("t4d", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
